sdram_wr_burst_feeder: RTL and testbench
========================================

Name: sdram_wr_burst_feeder

Overview:
Write-side feeder directly upstream of the SDRAM data-path stage; it produces that stage's DATAIN and DM inputs. It buffers host write words (data plus byte enables) in a small FIFO. On a burst request from the SDRAM control path, it releases exactly BURST_LEN words as one contiguous, cycle-aligned beat stream. Outside a burst, DM is held all-ones, so no byte is ever written by accident.

Parameters:
DSIZE, 16, data width in bits; must be a multiple of 8.
BURST_LEN, 8, words per SDRAM write burst; range 1..FIFO_DEPTH.
FIFO_DEPTH, 16, buffer depth in words; power of 2, at least BURST_LEN.

Ports:
CLK  in  1  system clock, shared with the SDRAM control and data path.
RESET  in  1  synchronous, active-high reset.
WR_DATA  in  DSIZE  host write word.
WR_BE  in  DSIZE/8  host byte enables; 1 = write the byte.
WR_VALID  in  1  host word valid.
WR_READY  out  1  FIFO can accept a word.
BURST_REQ  in  1  control path requests a write burst (level, sampled each cycle).
BURST_RDY  out  1  FIFO holds at least BURST_LEN words.
BURST_ACK  out  1  one-cycle pulse marking the first beat of an accepted burst.
BURST_BUSY  out  1  high on every cycle DATAIN/DM carry a burst beat.
DATAIN  out  DSIZE  data to the data-path stage.
DM  out  DSIZE/8  byte masks to the data-path stage; 1 = masked.
FILL_LEVEL  out  clog2(FIFO_DEPTH)+1  current FIFO word count.

Behaviour:
- Synchronous reset; all state changes on the rising edge of CLK.
- Reset values:
  - FIFO empty, FILL_LEVEL=0, WR_READY=1, BURST_RDY=0.
  - BURST_ACK=0, BURST_BUSY=0, DATAIN=0, DM=all ones.
  - State IDLE, beat counter 0.
- Reset mid-burst: on the next edge the FIFO is flushed, the burst is aborted with no further beats, and all outputs return to reset values.
- FIFO:
  - WR_READY = (FILL_LEVEL < FIFO_DEPTH), combinational from the registered count.
  - Push when WR_VALID & WR_READY. WR_DATA is stored with its mask ~WR_BE.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged; a push is accepted when full only if a pop occurs in the same cycle? No: WR_READY uses the pre-pop count, so a full FIFO refuses pushes.
  - BURST_RDY = (FILL_LEVEL >= BURST_LEN), from the registered count.
- State machine, states IDLE and SEND:
  - IDLE: if BURST_REQ & BURST_RDY, pop word 0 and go to SEND with beat=0. Otherwise there is no pop, and the request is silently ignored (no ACK); the control path keeps requesting.
  - SEND: pop one word per cycle while beat < BURST_LEN-1, incrementing beat. When beat == BURST_LEN-1, do not pop and return to IDLE.
  - BURST_REQ is ignored while in SEND. A new burst needs at least one IDLE cycle, so bursts are spaced by at least one idle gap.
- Output timing (registered, 1-cycle latency from pop):
  - If a request is accepted at edge T, DATAIN/DM show word 0 during cycle T+1 and word k during cycle T+1+k, for k = 0..BURST_LEN-1.
  - BURST_ACK=1 during cycle T+1 only.
  - BURST_BUSY=1 during cycles T+1 .. T+BURST_LEN.
- When no beat is presented, DATAIN=0 and DM=all ones.
- Because a burst starts only with at least BURST_LEN words stored, underrun is impossible. Pushes during a burst are allowed.
- BURST_LEN=1: ACK and BUSY are both a single cycle; the FSM returns to IDLE immediately.

Test Plan:
- Reset: hold RESET 2 cycles -> DM=2'b11, DATAIN=0, WR_READY=1, FILL_LEVEL=0, BURST_ACK=0.
- Basic burst (DSIZE=16, BURST_LEN=8): push 0x1000..0x1007 with WR_BE=2'b11, then assert BURST_REQ -> ACK 1 cycle later; DATAIN 0x1000..0x1007 on 8 consecutive cycles with DM=2'b00 and BUSY=1; then DM=2'b11 and FILL_LEVEL=0.
- Byte masks: push word 0xABCD with WR_BE=2'b01 inside a burst -> that beat shows DATAIN=0xABCD, DM=2'b10.
- Not ready: push 7 words, hold BURST_REQ high -> no ACK and DM stays 2'b11. Push an 8th word -> ACK on the second cycle after that push.
- Full and concurrent traffic: fill 16 words -> WR_READY=0 and further pushes are dropped. Start a burst while pushing continuously -> FILL_LEVEL never exceeds 16, and all data comes out in order with no loss.
- Reset mid-burst: assert RESET at beat 3 -> from the next cycle BUSY=0, DM=2'b11, FILL_LEVEL=0; after release, a new 8-word push and burst returns the new data.

Source files
------------

// File: rtl/sdram_wr_burst_feeder_if.sv
// rtl/sdram_wr_burst_feeder_if.sv - host write, burst control and SDRAM data-path signals of the write feeder
interface sdram_wr_burst_feeder_if #(
  parameter int DSIZE      = 16,
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DSIZE-1:0]   WR_DATA;
  logic [DSIZE/8-1:0] WR_BE;
  logic               WR_VALID;
  logic               WR_READY;
  logic               BURST_REQ;
  logic               BURST_RDY;
  logic               BURST_ACK;
  logic               BURST_BUSY;
  logic [DSIZE-1:0]   DATAIN;
  logic [DSIZE/8-1:0] DM;
  logic [CW-1:0]      FILL_LEVEL;

  // Host and SDRAM control path side.
  modport master (
    output WR_DATA, WR_BE, WR_VALID, BURST_REQ,
    input  WR_READY, BURST_RDY, BURST_ACK, BURST_BUSY, DATAIN, DM, FILL_LEVEL
  );

  // Feeder side.
  modport slave (
    input  WR_DATA, WR_BE, WR_VALID, BURST_REQ,
    output WR_READY, BURST_RDY, BURST_ACK, BURST_BUSY, DATAIN, DM, FILL_LEVEL
  );

endinterface

// File: rtl/sdram_wr_burst_feeder.sv
// rtl/sdram_wr_burst_feeder.sv - buffers host write words and releases them as fixed-length SDRAM write bursts
module sdram_wr_burst_feeder #(
  parameter int DSIZE      = 16,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sdram_wr_burst_feeder_if.slave bus
);

  localparam int BEW = DSIZE / 8;
  localparam int WW  = DSIZE + BEW;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  BL_C      = CW'(BURST_LEN);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] beat_q, beat_d;

  // Each entry holds {mask, data}; the mask is stored already inverted from
  // the byte enables so it can go straight onto DM.
  logic [WW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [DSIZE-1:0] dout_q, dout_d;
  logic [BEW-1:0]   dm_q, dm_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic          wr_ready;
  logic          burst_rdy;
  logic          push;
  logic          pop;
  logic          first;
  logic [WW-1:0] rd_word;

  // Both flags come from the registered count, so a full FIFO refuses a
  // push even when a beat is popped in the same cycle.
  assign wr_ready  = (count_q < DEPTH_C);
  assign burst_rdy = (count_q >= BL_C);
  assign push      = bus.WR_VALID & wr_ready;
  assign rd_word   = mem_q[rd_ptr_q];

  // Burst sequencer: the IDLE cycle pops beat 0, SEND pops the rest and
  // spends its final cycle presenting the last beat without popping, which
  // guarantees an idle gap before the next burst can be accepted.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    first   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.BURST_REQ && burst_rdy) begin
          pop     = 1'b1;
          first   = 1'b1;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_q != BEAT_LAST) begin
          pop    = 1'b1;
          beat_d = beat_q + BCW'(1);
        end else begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        beat_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Beat presentation: a popped word appears on the next cycle, otherwise
  // the data path sees zero data with every byte masked.
  always_comb begin
    dout_d = '0;
    dm_d   = '1;
    ack_d  = 1'b0;
    busy_d = 1'b0;
    if (pop) begin
      dout_d = rd_word[DSIZE-1:0];
      dm_d   = rd_word[WW-1:DSIZE];
      ack_d  = first;
      busy_d = 1'b1;
    end
  end

  // Word storage; contents need no reset because the count gates every read.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {~bus.WR_BE, bus.WR_DATA};
    end
  end

  // State, FIFO bookkeeping and output registers; reset also aborts a burst.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dm_q     <= '1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dm_q     <= dm_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.WR_READY   = wr_ready;
  assign bus.BURST_RDY  = burst_rdy;
  assign bus.BURST_ACK  = ack_q;
  assign bus.BURST_BUSY = busy_q;
  assign bus.DATAIN     = dout_q;
  assign bus.DM         = dm_q;
  assign bus.FILL_LEVEL = count_q;

endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// tb/tb_sdram_wr_burst_feeder.sv - scoreboard bench for the SDRAM write burst feeder
module tb_sdram_wr_burst_feeder;

  localparam int BL    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [1:0]  dm;
    bit          first;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   mcount;
  bit   msend;
  int   mbeat;
  bit   started;

  logic [17:0] mf[$];
  beat_t       sbq[$];

  sdram_wr_burst_feeder_if #(.DSIZE(16), .FIFO_DEPTH(DEPTH)) bus ();

  sdram_wr_burst_feeder #(
    .DSIZE(16),
    .BURST_LEN(BL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock with the given inputs; the reference model advances at the edge.
  task automatic step(input bit r, input bit v, input logic [15:0] d,
                      input logic [1:0] be, input bit req);
    bit    push_ok;
    bit    pop;
    beat_t e;
    logic [17:0] w;
    rst           = r;
    bus.WR_VALID  = v;
    bus.WR_DATA   = d;
    bus.WR_BE     = be;
    bus.BURST_REQ = req;
    @(posedge clk);
    cyc++;
    if (r) begin
      mf.delete();
      sbq.delete();
      mcount = 0;
      msend  = 1'b0;
      mbeat  = 0;
    end else begin
      push_ok = v && (mcount < DEPTH);
      pop     = 1'b0;
      if (!msend) begin
        if (req && mcount >= BL) begin
          pop   = 1'b1;
          msend = 1'b1;
          mbeat = 0;
          for (int k = 0; k < BL; k++) begin
            w       = mf.pop_front();
            e.cyc   = cyc + k;
            e.data  = w[15:0];
            e.dm    = w[17:16];
            e.first = (k == 0);
            sbq.push_back(e);
          end
        end
      end else if (mbeat < BL - 1) begin
        pop = 1'b1;
        mbeat++;
      end else begin
        msend = 1'b0;
      end
      if (push_ok) mf.push_back({~be, d});
      mcount = mcount + int'(push_ok) - int'(pop);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] be);
    step(1'b0, 1'b1, d, be, 1'b0);
  endtask

  // Monitor: every beat must match the scoreboard head in data, mask, ACK and cycle.
  always @(negedge clk) begin
    beat_t e;
    if (started) begin
      if (bus.BURST_BUSY === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_data", bus.DATAIN, e.data);
          chk("beat_dm", bus.DM, e.dm);
          chk("beat_ack", bus.BURST_ACK, e.first);
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          chk("missing_beat", 32'd0, 32'd1);
        end
        chk("idle_datain", bus.DATAIN, 32'd0);
        chk("idle_dm", bus.DM, 32'd3);
        chk("idle_ack", bus.BURST_ACK, 32'd0);
      end
      chk("fill_level", bus.FILL_LEVEL, mcount);
      chk("wr_ready", bus.WR_READY, (mcount < DEPTH));
      chk("burst_rdy", bus.BURST_RDY, (mcount >= BL));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    mcount  = 0;
    msend   = 1'b0;
    mbeat   = 0;
    started = 1'b0;
    rst     = 1'b1;
    bus.WR_VALID  = 1'b0;
    bus.WR_DATA   = '0;
    bus.WR_BE     = '0;
    bus.BURST_REQ = 1'b0;

    // Reset held for two cycles.
    step(1'b1, 1'b0, 16'h0, 2'b00, 1'b0);
    started = 1'b1;
    step(1'b1, 1'b0, 16'h0, 2'b00, 1'b0);
    chk("rst_dm", bus.DM, 32'd3);
    chk("rst_datain", bus.DATAIN, 32'd0);
    chk("rst_wr_ready", bus.WR_READY, 32'd1);
    chk("rst_fill", bus.FILL_LEVEL, 32'd0);
    chk("rst_ack", bus.BURST_ACK, 32'd0);
    chk("rst_busy", bus.BURST_BUSY, 32'd0);

    // Basic burst of 0x1000..0x1007, all bytes enabled.
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 2'b11);
    chk("basic_rdy", bus.BURST_RDY, 32'd1);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    chk("basic_ack", bus.BURST_ACK, 32'd1);
    chk("basic_w0", bus.DATAIN, 32'h1000);
    chk("basic_dm0", bus.DM, 32'd0);
    idle(10);
    chk("basic_fill_end", bus.FILL_LEVEL, 32'd0);
    chk("basic_dm_end", bus.DM, 32'd3);

    // Byte masks: word 3 carries only its low byte enable.
    for (int i = 0; i < 3; i++) push(16'h2000 + 16'(i), 2'b11);
    push(16'hABCD, 2'b01);
    push(16'h2004, 2'b10);
    push(16'h2005, 2'b00);
    push(16'h2006, 2'b11);
    push(16'h2007, 2'b01);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    idle(3);
    chk("mask_data", bus.DATAIN, 32'hABCD);
    chk("mask_dm", bus.DM, 32'd2);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
    chk("mask_dm4", bus.DM, 32'd1);
    idle(8);

    // Not ready: seven words with the request held gives no burst.
    for (int i = 0; i < 7; i++) push(16'h3000 + 16'(i), 2'b11);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
      chk("nr_ack", bus.BURST_ACK, 32'd0);
      chk("nr_dm", bus.DM, 32'd3);
    end
    step(1'b0, 1'b1, 16'h3007, 2'b11, 1'b1);
    chk("nr_ack_first", bus.BURST_ACK, 32'd0);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    chk("nr_ack_second", bus.BURST_ACK, 32'd1);
    chk("nr_w0", bus.DATAIN, 32'h3000);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b0);
    idle(10);

    // Full FIFO refuses further pushes.
    for (int i = 0; i < 16; i++) push(16'h4000 + 16'(i), 2'b11);
    for (int i = 0; i < 3; i++) push(16'h5000 + 16'(i), 2'b11);
    chk("full_ready", bus.WR_READY, 32'd0);
    chk("full_fill", bus.FILL_LEVEL, 32'd16);

    // Bursts while pushing every cycle, then drain.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 16'h6000 + 16'(i), 2'b11, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    idle(3);

    // Reset at beat 3 of a burst.
    for (int i = 0; i < 8; i++) push(16'h7000 + 16'(i), 2'b11);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    idle(3);
    chk("mid_busy_before", bus.BURST_BUSY, 32'd1);
    step(1'b1, 1'b0, 16'h0, 2'b00, 1'b0);
    chk("mid_busy", bus.BURST_BUSY, 32'd0);
    chk("mid_dm", bus.DM, 32'd3);
    chk("mid_fill", bus.FILL_LEVEL, 32'd0);
    idle(2);
    for (int i = 0; i < 8; i++) push(16'h8000 + 16'(i), 2'b11);
    step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
    chk("post_w0", bus.DATAIN, 32'h8000);
    idle(12);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
